// File: rtl/lcd_window_feeder_if.sv
// Bundle between lcd_window_feeder, the LCD write-strobe controller and the
// frame memory.
//
// Handshake:
//   wr_en      one-cycle pulse that opens a burst. The first word is already
//              valid on lcd_rs/lcd_data in that cycle.
//   lcd_rs/lcd_data  the current word. It is held until the controller raises
//              wr_addr_en for one cycle. wr_addr_en means "this word was
//              strobed, advance". The next word appears in the following cycle.
//   wr_stop    high while the current word is the last of the burst, so the
//              controller can sample it together with that word's wr_addr_en.
//   mem_rd/mem_addr  read request. mem_rdata is valid in the next cycle.
interface lcd_window_feeder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 17
) ();
  logic              wr_en;
  logic              wr_stop;
  logic              wr_addr_en;
  logic              lcd_rs;
  logic [DATA_W-1:0] lcd_data;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output wr_en, wr_stop, lcd_rs, lcd_data, mem_rd, mem_addr,
    input  wr_addr_en, mem_rdata
  );

  modport slave (
    input  wr_en, wr_stop, lcd_rs, lcd_data, mem_rd, mem_addr,
    output wr_addr_en, mem_rdata
  );
endinterface

// File: rtl/lcd_window_feeder.sv
// lcd_window_feeder: streams the column-set / page-set / memory-write command
// words and then win_w*win_h frame-memory pixels to the LCD write controller,
// one word per wr_addr_en beat.
// Optional feature macro: LCD_FEEDER_FILL_EN adds fill_mode/fill_color. When
// fill_mode is set, the pixel words are a constant colour and the frame memory
// is not read.
module lcd_window_feeder #(
  parameter int         DATA_W   = 16,
  parameter int         ADDR_W   = 17,
  parameter int         COORD_W  = 9,
  parameter logic [7:0] CMD_COL  = 8'h2A,
  parameter logic [7:0] CMD_PAGE = 8'h2B,
  parameter logic [7:0] CMD_MWR  = 8'h2C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] win_xs,
  input  logic [COORD_W-1:0] win_ys,
  input  logic [COORD_W-1:0] win_w,
  input  logic [COORD_W-1:0] win_h,
`ifdef LCD_FEEDER_FILL_EN
  input  logic               fill_mode,
  input  logic [DATA_W-1:0]  fill_color,
`endif
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg,
  lcd_window_feeder_if.master bus
);

  localparam int PIX_W = 2 * COORD_W;
  localparam int IDX_W = PIX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME1 = 2'd1,
    S_PRIME2 = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] xs_q, ys_q, w_q, h_q;
  logic [IDX_W-1:0]   idx_q, nxt_idx, last_idx;
  logic [PIX_W-1:0]   n_pix, rd_cnt_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  pix_q, pix_word, nxt_word, lcd_data_q;
  logic               lcd_rs_q, nxt_rs, wr_en_q, done_q, rd_pend_q;
  logic [15:0]        xs16, xe16, ys16, ye16;
  logic               win_zero, start_ok, start_zero, strobe, is_last, pix_rd;
  logic               fill_q;
  logic [DATA_W-1:0]  fill_color_q;

  // The window end coordinates are 16-bit quantities on the panel bus and wrap at 2^16.
  assign xs16     = 16'(xs_q);
  assign ys16     = 16'(ys_q);
  assign xe16     = xs16 + 16'(w_q) - 16'd1;
  assign ye16     = ys16 + 16'(h_q) - 16'd1;
  assign n_pix    = PIX_W'(w_q) * PIX_W'(h_q);
  assign last_idx = IDX_W'(n_pix) + IDX_W'(10);
  assign nxt_idx  = idx_q + IDX_W'(1);
  assign is_last  = (idx_q == last_idx);

  assign win_zero   = (win_w == '0) || (win_h == '0);
  assign start_ok   = (state_q == S_IDLE) && start && !win_zero;
  assign start_zero = (state_q == S_IDLE) && start && win_zero;
  assign strobe     = (state_q == S_STREAM) && bus.wr_addr_en;

  // The read for pixel k+1 is issued on the beat that moves pixel k onto the bus.
  assign pix_rd   = strobe && !is_last && (nxt_idx >= IDX_W'(11)) &&
                    (rd_cnt_q < n_pix) && !fill_q;
  assign pix_word = fill_q ? fill_color_q : pix_q;

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign state_dbg    = state_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_stop  = (state_q == S_STREAM) && is_last;
  assign bus.lcd_rs   = lcd_rs_q;
  assign bus.lcd_data = lcd_data_q;

`ifdef LCD_FEEDER_FILL_EN
  // Latch the fill selection together with the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q       <= 1'b0;
      fill_color_q <= '0;
    end else if (start_ok) begin
      fill_q       <= fill_mode;
      fill_color_q <= fill_color;
    end
  end
`else
  assign fill_q       = 1'b0;
  assign fill_color_q = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and memory read strobe.
  always_comb begin
    state_d      = state_q;
    bus.mem_rd   = 1'b0;
    bus.mem_addr = mem_addr_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_PRIME1;
      S_PRIME1: begin
        state_d    = S_PRIME2;
        bus.mem_rd = !fill_q;
      end
      S_PRIME2: state_d = S_STREAM;
      S_STREAM: if (strobe && is_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (pix_rd) begin
      bus.mem_rd   = 1'b1;
      bus.mem_addr = mem_addr_q + ADDR_W'(1);
    end
  end

  // The word presented after the current one has been strobed.
  always_comb begin
    nxt_word = pix_word;
    nxt_rs   = 1'b1;
    if (nxt_idx < IDX_W'(11)) begin
      case (nxt_idx[3:0])
        4'd1:  nxt_word = DATA_W'(xs16[15:8]);
        4'd2:  nxt_word = DATA_W'(xs16[7:0]);
        4'd3:  nxt_word = DATA_W'(xe16[15:8]);
        4'd4:  nxt_word = DATA_W'(xe16[7:0]);
        4'd5:  begin nxt_word = DATA_W'(CMD_PAGE); nxt_rs = 1'b0; end
        4'd6:  nxt_word = DATA_W'(ys16[15:8]);
        4'd7:  nxt_word = DATA_W'(ys16[7:0]);
        4'd8:  nxt_word = DATA_W'(ye16[15:8]);
        4'd9:  nxt_word = DATA_W'(ye16[7:0]);
        4'd10: begin nxt_word = DATA_W'(CMD_MWR); nxt_rs = 1'b0; end
        default: nxt_word = pix_word;
      endcase
    end
  end

  // Window latch, word sequencing, pixel prefetch and the burst pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      xs_q       <= '0;
      ys_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      idx_q      <= '0;
      rd_cnt_q   <= '0;
      mem_addr_q <= '0;
      pix_q      <= '0;
      rd_pend_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      lcd_data_q <= '0;
      lcd_rs_q   <= 1'b0;
    end else begin
      wr_en_q   <= (state_q == S_PRIME2);
      done_q    <= start_zero || (strobe && is_last);
      rd_pend_q <= pix_rd;
      if (start_ok) begin
        xs_q       <= win_xs;
        ys_q       <= win_ys;
        w_q        <= win_w;
        h_q        <= win_h;
        idx_q      <= '0;
        rd_cnt_q   <= '0;
        mem_addr_q <= '0;
      end
      if ((state_q == S_PRIME1) && !fill_q) rd_cnt_q <= PIX_W'(1);
      if (state_q == S_PRIME2) begin
        pix_q      <= bus.mem_rdata;
        lcd_data_q <= DATA_W'(CMD_COL);
        lcd_rs_q   <= 1'b0;
        idx_q      <= '0;
      end
      if (rd_pend_q) pix_q <= bus.mem_rdata;
      if (strobe) begin
        if (is_last) begin
          idx_q      <= '0;
          lcd_data_q <= '0;
          lcd_rs_q   <= 1'b0;
        end else begin
          idx_q      <= nxt_idx;
          lcd_data_q <= nxt_word;
          lcd_rs_q   <= nxt_rs;
        end
      end
      if (pix_rd) begin
        mem_addr_q <= mem_addr_q + ADDR_W'(1);
        rd_cnt_q   <= rd_cnt_q + PIX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_window_feeder.sv
// Directed bench for lcd_window_feeder: controller model, frame-memory model,
// one task per scenario with inline comparisons.
`timescale 1ns/1ps
module tb_lcd_window_feeder;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 17;
  localparam int COORD_W = 9;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start = 1'b0;
  logic [COORD_W-1:0] win_xs = '0, win_ys = '0, win_w = '0, win_h = '0;
  logic               busy, done;
  logic [1:0]         state_dbg;
`ifdef LCD_FEEDER_FILL_EN
  logic               fill_mode = 1'b0;
  logic [DATA_W-1:0]  fill_color = '0;
`endif

  lcd_window_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  lcd_window_feeder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COORD_W(COORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .win_xs     (win_xs),
    .win_ys     (win_ys),
    .win_w      (win_w),
    .win_h      (win_h),
`ifdef LCD_FEEDER_FILL_EN
    .fill_mode  (fill_mode),
    .fill_color (fill_color),
`endif
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg),
    .bus        (bus.master)
  );

  // Frame memory: data valid the cycle after the read strobe.
  logic [15:0] mem [0:15];
  always @(posedge clk) begin
    if (rst) bus.mem_rdata <= '0;
    else if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end

  // Event counters sampled on the falling edge.
  int rd_cnt = 0, done_cnt = 0, wen_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_rd === 1'b1) rd_cnt++;
    if (done === 1'b1) done_cnt++;
    if (bus.wr_en === 1'b1) wen_cnt++;
  end

  // Scoreboard: {wr_stop, lcd_rs, lcd_data} per strobed word.
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int checks = 0;
  int failures = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one-cycle start with a window.
  task automatic start_frame(input logic [8:0] xs, ys, w, h);
    win_xs = xs; win_ys = ys; win_w = w; win_h = h;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Write-controller model: waits for wr_en, strobes each word after 4 cycles,
  // stops after the word flagged by wr_stop or after max_words strobes.
  // Optionally re-pulses start on the strobe of word pulse_at.
  task automatic ctrl_run(input int max_words, input int pulse_at);
    int t;
    t = 0;
    got_q.delete();
    while (bus.wr_en !== 1'b1 && t < 40) begin step(); t++; end
    checks++;
    if (bus.wr_en !== 1'b1) begin
      failures++;
      $display("FAIL wr_en_wait: wr_en=%b required 1 within 40 cycles", bus.wr_en);
      return;
    end
    for (int n = 0; n < max_words; n++) begin
      repeat (3) step();
      got_q.push_back({bus.wr_stop, bus.lcd_rs, bus.lcd_data});
      if (n == pulse_at) start = 1'b1;
      bus.wr_addr_en = 1'b1;
      step();
      bus.wr_addr_en = 1'b0;
      start = 1'b0;
      if (got_q[n][17]) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b required 0", bus.wr_en); end
    checks++; if (bus.mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd: got %b required 0", bus.mem_rd); end
    checks++; if (bus.mem_addr !== 17'd0) begin failures++; $display("FAIL reset_mem_addr: got %h required 0", bus.mem_addr); end
    checks++; if (bus.lcd_data !== 16'd0) begin failures++; $display("FAIL reset_lcd_data: got %h required 0", bus.lcd_data); end
    checks++; if (bus.lcd_rs !== 1'b0 || bus.wr_stop !== 1'b0) begin failures++; $display("FAIL reset_rs_stop: got %b%b required 00", bus.lcd_rs, bus.wr_stop); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_2x2();
    logic [15:0] d [15];
    int r0, d0, w0;
    d = '{16'h2A, 16'h00, 16'h05, 16'h00, 16'h06, 16'h2B, 16'h00, 16'h07,
          16'h00, 16'h08, 16'h2C, 16'hA0, 16'hA1, 16'hA2, 16'hA3};
    mem[0] = 16'hA0; mem[1] = 16'hA1; mem[2] = 16'hA2; mem[3] = 16'hA3;
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back({(i == 14), !(i == 0 || i == 5 || i == 10), d[i]});
    r0 = rd_cnt; d0 = done_cnt; w0 = wen_cnt;
    start_frame(9'd5, 9'd7, 9'd2, 9'd2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b required 1", busy); end
    ctrl_run(40, -1);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_end: done=%b busy=%b required done=1 busy=0", done, busy); end
    repeat (3) step();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rd_cnt - r0 != 4) begin failures++; $display("FAIL basic_reads: got %0d required 4", rd_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL basic_done: got %0d required 1", done_cnt - d0); end
    checks++; if (wen_cnt - w0 != 1) begin failures++; $display("FAIL basic_wr_en: got %0d required 1", wen_cnt - w0); end
  endtask

  task automatic test_reset_mid_stream();
    int d0;
    mem[0] = 16'hA0; mem[1] = 16'hA1; mem[2] = 16'hA2; mem[3] = 16'hA3;
    start_frame(9'd5, 9'd7, 9'd2, 9'd2);
    ctrl_run(13, -1);
    checks++; if (bus.lcd_data !== 16'hA2) begin failures++; $display("FAIL midrst_word13: got %h required 00a2", bus.lcd_data); end
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (bus.wr_en !== 1'b0 || bus.mem_rd !== 1'b0) begin failures++; $display("FAIL midrst_strobes: wr_en=%b mem_rd=%b required 0 0", bus.wr_en, bus.mem_rd); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL midrst_state: got %0d required 0", state_dbg); end
    repeat (3) step();
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL midrst_done: got %0d pulses required 0", done_cnt - d0); end
    start_frame(9'd5, 9'd7, 9'd2, 9'd2);
    ctrl_run(40, -1);
    repeat (2) step();
    checks++;
    if (got_q.size() != 15) begin failures++; $display("FAIL midrst_restart_count: got %0d words required 15", got_q.size()); end
    else if (got_q[14] !== {1'b1, 1'b1, 16'hA3}) begin failures++; $display("FAIL midrst_restart_last: got %h required 300a3", got_q[14]); end
  endtask

  task automatic test_corner_1x1();
    logic [15:0] d [12];
    int r0;
    d = '{16'h2A, 16'h01, 16'hDF, 16'h01, 16'hDF, 16'h2B, 16'h01, 16'h3F,
          16'h01, 16'h3F, 16'h2C, 16'h1234};
    mem[0] = 16'h1234;
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back({(i == 11), !(i == 0 || i == 5 || i == 10), d[i]});
    r0 = rd_cnt;
    start_frame(9'd479, 9'd319, 9'd1, 9'd1);
    ctrl_run(40, -1);
    repeat (2) step();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL corner_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL corner_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rd_cnt - r0 != 1) begin failures++; $display("FAIL corner_reads: got %0d required 1", rd_cnt - r0); end
  endtask

  task automatic test_zero_size();
    int r0, w0, d0;
    r0 = rd_cnt; w0 = wen_cnt; d0 = done_cnt;
    start_frame(9'd3, 9'd4, 9'd0, 9'd3);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done: done=%b busy=%b required done=1 busy=0", done, busy); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_width: got %b required 0", done); end
    repeat (10) step();
    checks++; if (wen_cnt != w0 || rd_cnt != r0) begin failures++; $display("FAIL zero_activity: wr_en=%0d reads=%0d required 0 0", wen_cnt - w0, rd_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL zero_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [20];
    int r0, w0, d0;
    d = '{16'h2A, 16'h00, 16'h01, 16'h00, 16'h03, 16'h2B, 16'h00, 16'h02,
          16'h00, 16'h04, 16'h2C, 16'hB0, 16'hB1, 16'hB2, 16'hB3, 16'hB4,
          16'hB5, 16'hB6, 16'hB7, 16'hB8};
    for (int i = 0; i < 9; i++) mem[i] = 16'hB0 + 16'(i);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back({(i == 19), !(i == 0 || i == 5 || i == 10), d[i]});
    r0 = rd_cnt; w0 = wen_cnt; d0 = done_cnt;
    start_frame(9'd1, 9'd2, 9'd3, 9'd3);
    win_w = 9'd1; win_h = 9'd1;
    ctrl_run(40, 12);
    repeat (20) step();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (wen_cnt - w0 != 1 || done_cnt - d0 != 1) begin failures++; $display("FAIL b2b_frames: wr_en=%0d done=%0d required 1 1", wen_cnt - w0, done_cnt - d0); end
    checks++; if (rd_cnt - r0 != 9) begin failures++; $display("FAIL b2b_reads: got %0d required 9", rd_cnt - r0); end
  endtask

`ifdef LCD_FEEDER_FILL_EN
  task automatic test_fill();
    logic [15:0] d [17];
    int r0;
    d = '{16'h2A, 16'h00, 16'h00, 16'h00, 16'h01, 16'h2B, 16'h00, 16'h00,
          16'h00, 16'h02, 16'h2C, 16'hF800, 16'hF800, 16'hF800, 16'hF800,
          16'hF800, 16'hF800};
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back({(i == 16), !(i == 0 || i == 5 || i == 10), d[i]});
    r0 = rd_cnt;
    fill_mode = 1'b1; fill_color = 16'hF800;
    start_frame(9'd0, 9'd0, 9'd2, 9'd3);
    fill_mode = 1'b0; fill_color = 16'h0000;
    ctrl_run(40, -1);
    repeat (2) step();
    checks++;
    if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fill_count: got %0d words required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fill_word[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rd_cnt != r0) begin failures++; $display("FAIL fill_reads: got %0d required 0", rd_cnt - r0); end
  endtask
`endif

  initial begin
    bus.wr_addr_en = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    test_reset();
    test_basic_2x2();
    test_reset_mid_stream();
    test_corner_1x1();
    test_zero_size();
    test_back_to_back();
`ifdef LCD_FEEDER_FILL_EN
    test_fill();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
